// File: rtl/crt_dma_responder.sv
// Memory-side DMA responder for the CRT controller: fetches one video-memory byte
// per drq, presents it on ochar with a dack strobe, and counts blocks down to tc.
module crt_dma_responder #(
  parameter int DACK_LEN = 2,
  parameter int HOLDOFF  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  iaddr,
  input  logic [7:0]  idata,
  output logic [7:0]  odata,
  input  logic        iwe_n,
  input  logic        ird_n,
  input  logic        drq,
  output logic        dack,
  output logic [7:0]  ochar,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [7:0]  mem_data,
  output logic        tc
);

  typedef enum logic [1:0] {IDLE, READ, ACK, GAP} state_e;

  localparam logic [3:0] DackLast = 4'(DACK_LEN);
  localparam logic [3:0] GapLast  = 4'(HOLDOFF - 1);
  localparam logic [1:0] RegAddr  = 2'd0;
  localparam logic [1:0] RegCnt   = 2'd1;
  localparam logic [1:0] RegMode  = 2'd2;
  localparam logic [1:0] RegStat  = 2'd3;

  state_e      state_q;
  logic [3:0]  ackCnt_q;
  logic [3:0]  gapCnt_q;
  logic        dack_q;
  logic        memRd_q;
  logic        tc_q;
  logic [7:0]  ochar_q;
  logic [15:0] memAddr_q;

  logic [15:0] baseAddr_q;
  logic [13:0] baseCnt_q;
  logic [15:0] curAddr_q;
  logic [13:0] curCnt_q;
  logic        enable_q;
  logic        autoload_q;
  logic        byteHi_q;
  logic        tcFlag_q;
  logic        update_q;

  logic        iweSync_q;
  logic        iwePrev_q;
  logic        irdSync_q;
  logic        irdPrev_q;
  logic        wrPend_q;
  logic [1:0]  wrAddr_q;
  logic [7:0]  wrData_q;

  logic        weEdge;
  logic        rdEdge;
  logic [15:0] addrInc_d;
  logic [13:0] cntDec_d;

  assign weEdge    = iweSync_q & ~iwePrev_q;
  assign rdEdge    = irdSync_q & ~irdPrev_q;
  assign addrInc_d = curAddr_q + 16'd1;
  assign cntDec_d  = curCnt_q - 14'd1;

  assign odata    = (iaddr == RegStat) ? {3'b000, update_q, 3'b000, tcFlag_q} : 8'h00;
  assign dack     = dack_q;
  assign ochar    = ochar_q;
  assign mem_addr = memAddr_q;
  assign mem_rd   = memRd_q;
  assign tc       = tc_q;

  // Strobe sync flops reset high so an idle-high strobe never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iweSync_q <= 1'b1;
      iwePrev_q <= 1'b1;
      irdSync_q <= 1'b1;
      irdPrev_q <= 1'b1;
      wrPend_q  <= 1'b0;
      wrAddr_q  <= 2'd0;
      wrData_q  <= 8'h00;
    end else begin
      iweSync_q <= iwe_n;
      iwePrev_q <= iweSync_q;
      irdSync_q <= ird_n;
      irdPrev_q <= irdSync_q;
      wrPend_q  <= weEdge;
      if (weEdge) begin
        wrAddr_q <= iaddr;
        wrData_q <= idata;
      end
    end
  end

  // Transfer FSM and register file; CPU writes are applied last so they win
  // over same-cycle FSM updates, and tc/update setting wins over a status read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ackCnt_q   <= 4'd0;
      gapCnt_q   <= 4'd0;
      dack_q     <= 1'b0;
      memRd_q    <= 1'b0;
      tc_q       <= 1'b0;
      ochar_q    <= 8'h00;
      memAddr_q  <= 16'h0000;
      baseAddr_q <= 16'h0000;
      baseCnt_q  <= 14'd0;
      curAddr_q  <= 16'h0000;
      curCnt_q   <= 14'd0;
      enable_q   <= 1'b0;
      autoload_q <= 1'b0;
      byteHi_q   <= 1'b0;
      tcFlag_q   <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;

      if (rdEdge && (iaddr == RegStat)) begin
        tcFlag_q <= 1'b0;
        update_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (enable_q && drq) begin
            memRd_q   <= 1'b1;
            memAddr_q <= curAddr_q;
            state_q   <= READ;
          end
        end
        READ: begin
          if (mem_ready) begin
            ochar_q  <= mem_data;
            memRd_q  <= 1'b0;
            ackCnt_q <= 4'd0;
            state_q  <= ACK;
          end
        end
        ACK: begin
          // ackCnt 0 is the ochar setup cycle; dack is high for counts 1..DACK_LEN.
          if (ackCnt_q == 4'd0) begin
            dack_q   <= 1'b1;
            ackCnt_q <= 4'd1;
          end else if (ackCnt_q != DackLast) begin
            ackCnt_q <= ackCnt_q + 4'd1;
          end else begin
            dack_q    <= 1'b0;
            curAddr_q <= addrInc_d;
            if (curCnt_q == 14'd0) begin
              tc_q     <= 1'b1;
              tcFlag_q <= 1'b1;
              if (autoload_q) begin
                curAddr_q <= baseAddr_q;
                curCnt_q  <= baseCnt_q;
                update_q  <= 1'b1;
              end else begin
                enable_q <= 1'b0;
              end
            end else begin
              curCnt_q <= cntDec_d;
            end
            if (HOLDOFF == 0) begin
              state_q <= IDLE;
            end else begin
              gapCnt_q <= 4'd0;
              state_q  <= GAP;
            end
          end
        end
        GAP: begin
          if (gapCnt_q == GapLast) begin
            state_q <= IDLE;
          end else begin
            gapCnt_q <= gapCnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (wrPend_q) begin
        case (wrAddr_q)
          RegAddr: begin
            if (!byteHi_q) begin
              baseAddr_q[7:0] <= wrData_q;
              byteHi_q        <= 1'b1;
            end else begin
              baseAddr_q[15:8] <= wrData_q;
              curAddr_q        <= {wrData_q, baseAddr_q[7:0]};
              byteHi_q         <= 1'b0;
            end
          end
          RegCnt: begin
            if (!byteHi_q) begin
              baseCnt_q[7:0] <= wrData_q;
              byteHi_q       <= 1'b1;
            end else begin
              baseCnt_q[13:8] <= wrData_q[5:0];
              curCnt_q        <= {wrData_q[5:0], baseCnt_q[7:0]};
              byteHi_q        <= 1'b0;
            end
          end
          RegMode: begin
            enable_q   <= wrData_q[0];
            autoload_q <= wrData_q[7];
            byteHi_q   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crt_dma_responder.sv
// Scoreboard bench for crt_dma_responder: expected transfers are queued when a
// block is programmed and checked against each dack pulse.
module tb_crt_dma_responder;

  localparam int DackLen = 2;
  localparam int Holdoff = 1;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        tc;
  } xfer_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  iaddr;
  logic [7:0]  idata;
  logic [7:0]  odata;
  logic        iwe_n;
  logic        ird_n;
  logic        drq;
  logic        dack;
  logic [7:0]  ochar;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [7:0]  mem_data;
  logic        tc;

  int checks = 0;
  int errors = 0;

  xfer_t       expQ[$];
  logic [7:0]  memQ[$];
  int          riseCycles[$];
  int          memLatency = 1;
  int          dackCount = 0;
  int          tcCount = 0;
  int          memRdCount = 0;
  int          unexpected = 0;
  int          cycleCnt = 0;
  logic [15:0] rdAddr = 16'h0000;
  logic        lastTc = 1'b0;

  crt_dma_responder #(.DACK_LEN(DackLen), .HOLDOFF(Holdoff)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .iaddr     (iaddr),
    .idata     (idata),
    .odata     (odata),
    .iwe_n     (iwe_n),
    .ird_n     (ird_n),
    .drq       (drq),
    .dack      (dack),
    .ochar     (ochar),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .tc        (tc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic cpuWrite(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iaddr = a;
    idata = d;
    iwe_n = 1'b0;
    repeat (2) @(negedge clk);
    iwe_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic cpuRead(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iaddr = a;
    ird_n = 1'b0;
    @(negedge clk);
    d = odata;
    ird_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [13:0] cnt, input logic [7:0] mode);
    cpuWrite(2'd2, 8'h00);
    cpuWrite(2'd0, addr[7:0]);
    cpuWrite(2'd0, addr[15:8]);
    cpuWrite(2'd1, cnt[7:0]);
    cpuWrite(2'd1, {2'b11, cnt[13:8]});
    cpuWrite(2'd2, mode);
  endtask

  // Expected transfers: address offset restarts after cnt+1 bytes under autoload.
  task automatic pushXfers(input logic [15:0] base, input int cnt, input int n,
                           input bit autoload, input logic [7:0] firstData);
    xfer_t e;
    for (int i = 0; i < n; i++) begin
      int off;
      off = autoload ? (i % (cnt + 1)) : i;
      e.addr = base + 16'(off);
      e.data = firstData + 8'(i);
      e.tc   = (off == cnt);
      expQ.push_back(e);
      memQ.push_back(e.data);
    end
  endtask

  task automatic waitDrain(input int maxCycles, input string tag);
    for (int i = 0; i < maxCycles && expQ.size() != 0; i++) @(negedge clk);
    checkOutput(tag, expQ.size(), 0);
    expQ.delete();
    memQ.delete();
  endtask

  // Memory model: answers mem_rd after memLatency falling edges.
  initial begin
    int waitCnt;
    mem_ready = 1'b0;
    mem_data  = 8'h00;
    waitCnt   = 0;
    forever begin
      @(negedge clk);
      if (mem_rd && !mem_ready) begin
        if (waitCnt >= memLatency - 1) begin
          mem_ready = 1'b1;
          if (memQ.size() != 0) mem_data = memQ.pop_front();
          else mem_data = 8'hEE;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        mem_ready = 1'b0;
        waitCnt   = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each dack rise, checks pulse width and tc at the fall.
  initial begin
    logic  prevDack;
    logic  prevMemRd;
    logic  prevTc;
    int    highLen;
    xfer_t e;
    prevDack = 1'b0;
    prevMemRd = 1'b0;
    prevTc = 1'b0;
    highLen = 0;
    forever begin
      @(negedge clk);
      cycleCnt++;
      if (!reset_n) begin
        prevDack = 1'b0;
        prevMemRd = 1'b0;
        prevTc = 1'b0;
        highLen = 0;
      end else begin
        if (mem_rd && !prevMemRd) begin
          rdAddr = mem_addr;
          memRdCount++;
        end
        if (tc && !prevTc) tcCount++;
        if (dack && !prevDack) begin
          dackCount++;
          riseCycles.push_back(cycleCnt);
          highLen = 1;
          if (expQ.size() == 0) begin
            unexpected++;
            lastTc = 1'b0;
          end else begin
            e = expQ.pop_front();
            checkOutput("ochar", 32'(ochar), 32'(e.data));
            checkOutput("memAddr", 32'(rdAddr), 32'(e.addr));
            lastTc = e.tc;
          end
        end else if (dack) begin
          highLen++;
        end else if (prevDack) begin
          checkOutput("dackLen", highLen, DackLen);
          checkOutput("tcAlign", 32'(tc), 32'(lastTc));
        end
        prevDack = dack;
        prevMemRd = mem_rd;
        prevTc = tc;
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] st;
    int d0, t0, u0, r0;
    reset_n = 1'b0;
    iaddr = 2'd3;
    idata = 8'h00;
    iwe_n = 1'b1;
    ird_n = 1'b1;
    drq = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstDack", 32'(dack), 0);
    checkOutput("rstMemRd", 32'(mem_rd), 0);
    checkOutput("rstTc", 32'(tc), 0);
    checkOutput("rstOchar", 32'(ochar), 0);
    checkOutput("rstMemAddr", 32'(mem_addr), 0);
    checkOutput("rstStatus", 32'(odata), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single block, 3 bytes, no autoload");
    d0 = dackCount; t0 = tcCount; u0 = unexpected;
    riseCycles.delete();
    applyStimulus(16'h76D0, 14'd2, 8'h01);
    pushXfers(16'h76D0, 2, 3, 1'b0, 8'h41);
    drq = 1'b1;
    waitDrain(300, "t1Drain");
    repeat (30) @(negedge clk);
    checkOutput("t1Dacks", dackCount - d0, 3);
    checkOutput("t1Tc", tcCount - t0, 1);
    checkOutput("t1Extra", unexpected - u0, 0);
    checkOutput("t1Rises", riseCycles.size(), 3);
    if (riseCycles.size() >= 2)
      checkOutput("t1Period", riseCycles[1] - riseCycles[0], 1 + 1 + DackLen + Holdoff + 1);
    drq = 1'b0;
    cpuRead(2'd3, st);
    checkOutput("t1Status", 32'(st), 32'h01);
    cpuRead(2'd3, st);
    checkOutput("t1StatusClr", 32'(st), 32'h00);

    $display("[TB] autoload, 6 bytes");
    d0 = dackCount; t0 = tcCount; u0 = unexpected;
    applyStimulus(16'h76D0, 14'd2, 8'h81);
    pushXfers(16'h76D0, 2, 6, 1'b1, 8'h50);
    drq = 1'b1;
    waitDrain(500, "t2Drain");
    drq = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t2Dacks", dackCount - d0, 6);
    checkOutput("t2Tc", tcCount - t0, 2);
    checkOutput("t2Extra", unexpected - u0, 0);
    cpuRead(2'd3, st);
    checkOutput("t2Status", 32'(st), 32'h11);
    cpuRead(2'd3, st);
    checkOutput("t2StatusClr", 32'(st), 32'h00);

    $display("[TB] address wrap at FFFF");
    d0 = dackCount; t0 = tcCount; u0 = unexpected;
    applyStimulus(16'hFFFF, 14'd1, 8'h01);
    pushXfers(16'hFFFF, 1, 2, 1'b0, 8'h60);
    drq = 1'b1;
    waitDrain(300, "t3Drain");
    repeat (20) @(negedge clk);
    drq = 1'b0;
    checkOutput("t3Dacks", dackCount - d0, 2);
    checkOutput("t3Tc", tcCount - t0, 1);
    checkOutput("t3Extra", unexpected - u0, 0);
    cpuRead(2'd3, st);
    checkOutput("t3Status", 32'(st), 32'h01);

    $display("[TB] memory stall");
    d0 = dackCount;
    memLatency = 21;
    applyStimulus(16'h1234, 14'd0, 8'h01);
    pushXfers(16'h1234, 0, 1, 1'b0, 8'h5A);
    drq = 1'b1;
    for (int i = 0; i < 50 && !mem_rd; i++) @(negedge clk);
    checkOutput("t4MemRd", 32'(mem_rd), 1);
    drq = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i % 3 == 0) begin
        checkOutput("t4HoldRd", 32'(mem_rd), 1);
        checkOutput("t4HoldAddr", 32'(mem_addr), 32'h1234);
        checkOutput("t4NoDack", 32'(dack), 0);
      end
    end
    waitDrain(100, "t4Drain");
    repeat (10) @(negedge clk);
    memLatency = 1;
    checkOutput("t4Dacks", dackCount - d0, 1);
    cpuRead(2'd3, st);
    checkOutput("t4Status", 32'(st), 32'h01);

    $display("[TB] reset during ACK");
    applyStimulus(16'h2000, 14'd5, 8'h01);
    pushXfers(16'h2000, 5, 1, 1'b0, 8'h77);
    drq = 1'b1;
    for (int i = 0; i < 50 && !dack; i++) @(negedge clk);
    checkOutput("t5DackSeen", 32'(dack), 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t5RstDack", 32'(dack), 0);
    checkOutput("t5RstMemRd", 32'(mem_rd), 0);
    checkOutput("t5RstTc", 32'(tc), 0);
    iaddr = 2'd3;
    #1;
    checkOutput("t5RstStatus", 32'(odata), 0);
    @(negedge clk);
    reset_n = 1'b1;
    expQ.delete();
    memQ.delete();
    d0 = dackCount; r0 = memRdCount;
    repeat (30) @(negedge clk);
    checkOutput("t5NoRead", memRdCount - r0, 0);
    checkOutput("t5NoDack", dackCount - d0, 0);
    drq = 1'b0;

    $display("[TB] byte flip-flop reset by mode write");
    d0 = dackCount; u0 = unexpected;
    cpuWrite(2'd2, 8'h00);
    cpuWrite(2'd0, 8'h11);
    cpuWrite(2'd2, 8'h00);
    cpuWrite(2'd0, 8'hAB);
    cpuWrite(2'd0, 8'hCD);
    cpuWrite(2'd1, 8'h00);
    cpuWrite(2'd1, 8'h00);
    cpuWrite(2'd2, 8'h01);
    pushXfers(16'hCDAB, 0, 1, 1'b0, 8'h3C);
    drq = 1'b1;
    waitDrain(100, "t6Drain");
    repeat (10) @(negedge clk);
    drq = 1'b0;
    checkOutput("t6Dacks", dackCount - d0, 1);
    checkOutput("t6Extra", unexpected - u0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
